// File: rtl/ysyx_23060191_ifu_pkg.sv
// Shared fetch-unit definitions: machine width, reset PC and fetch FSM encoding.
package ysyx_23060191_ifu_pkg;

  localparam int              CPU_WIDTH    = 32;
  localparam logic [31:0]     CPU_RESET_PC = 32'h8000_0000;

  typedef enum logic [1:0] {
    FS_IDLE = 2'd0,
    FS_REQ  = 2'd1,
    FS_WAIT = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/ysyx_23060191_ifu_fifo.sv
// Synchronous prefetch FIFO with flush; flush overrides push and pop.
module ysyx_23060191_ifu_fifo #(
  parameter int WIDTH = 65,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     head_valid,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wptr_r;
  logic [AW-1:0]    rptr_r;
  logic [CW-1:0]    count_r;
  logic             do_push_s;
  logic             do_pop_s;

  assign do_push_s  = push & (count_r != CW'(DEPTH));
  assign do_pop_s   = pop & (count_r != CW'(1'b0));
  assign head       = mem_r[rptr_r];
  assign head_valid = (count_r != CW'(1'b0));
  assign count      = count_r;

  // Storage, pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_r  <= '0;
      rptr_r  <= '0;
      count_r <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else if (flush) begin
      wptr_r  <= '0;
      rptr_r  <= '0;
      count_r <= '0;
    end else begin
      if (do_push_s) begin
        mem_r[wptr_r] <= push_data;
        wptr_r        <= wptr_r + AW'(1'b1);
      end
      if (do_pop_s) begin
        rptr_r <= rptr_r + AW'(1'b1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CW'(1'b1);
        2'b01:   count_r <= count_r - CW'(1'b1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/ysyx_23060191_ifu_prefetch_chk.sv
// Protocol checks for the fetch unit: responses only in WAIT, pushes never hit a full queue.
module ysyx_23060191_ifu_prefetch_chk
  import ysyx_23060191_ifu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  fetch_state_e           state,
  input  logic                   rsp_valid,
  input  logic                   push,
  input  logic [$clog2(DEPTH):0] count
);

  rsp_only_in_wait: assert property (@(posedge clk) disable iff (rst)
    rsp_valid |-> (state == FS_WAIT));

  push_has_credit: assert property (@(posedge clk) disable iff (rst)
    push |-> (count < ($clog2(DEPTH) + 1)'(DEPTH)));

endmodule

// File: rtl/ysyx_23060191_ifu_prefetch.sv
// Multi-cycle fetch unit: owns the PC, issues one word read at a time and
// queues the returned instructions with their PCs for the decoder.
module ysyx_23060191_ifu_prefetch
  import ysyx_23060191_ifu_pkg::*;
#(
  parameter int              XLEN     = CPU_WIDTH,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = CPU_RESET_PC
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_redirect_valid,
  input  logic [XLEN-1:0] i_redirect_pc,
  output logic            o_mem_req_valid,
  output logic [XLEN-1:0] o_mem_req_addr,
  input  logic            i_mem_req_ready,
  input  logic            i_mem_rsp_valid,
  input  logic [XLEN-1:0] i_mem_rsp_data,
  input  logic            i_mem_rsp_err,
  output logic            o_inst_valid,
  output logic [XLEN-1:0] o_inst,
  output logic [XLEN-1:0] o_inst_pc,
  output logic            o_inst_err,
  input  logic            i_inst_ready
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int EW = 2 * XLEN + 1;

  fetch_state_e    state_r;
  fetch_state_e    next_state_s;
  logic [XLEN-1:0] pc_r;
  logic [XLEN-1:0] req_addr_r;
  logic            drop_r;
  logic            issue_s;
  logic            push_s;
  logic            pop_s;
  logic [CW-1:0]   fifo_count_s;
  logic [EW-1:0]   head_s;
  logic            head_valid_s;

  // A slot is reserved before issuing, so a push can never find the queue full.
  assign issue_s = (state_r == FS_IDLE) & ~i_redirect_valid & (fifo_count_s < CW'(DEPTH));
  assign push_s  = (state_r == FS_WAIT) & i_mem_rsp_valid & ~drop_r & ~i_redirect_valid;
  assign pop_s   = head_valid_s & i_inst_ready;

  // Fetch state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= FS_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Fetch next-state logic
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      FS_IDLE: begin
        if (issue_s) next_state_s = FS_REQ;
        else         next_state_s = FS_IDLE;
      end
      FS_REQ: begin
        if (i_mem_req_ready) next_state_s = FS_WAIT;
        else                 next_state_s = FS_REQ;
      end
      FS_WAIT: begin
        if (i_mem_rsp_valid) next_state_s = FS_IDLE;
        else                 next_state_s = FS_WAIT;
      end
      default: next_state_s = FS_IDLE;
    endcase
  end

  // Request channel outputs decoded from the state register
  always_comb begin
    o_mem_req_valid = 1'b0;
    case (state_r)
      FS_REQ:  o_mem_req_valid = 1'b1;
      default: o_mem_req_valid = 1'b0;
    endcase
  end

  assign o_mem_req_addr = req_addr_r;

  // PC, request address and response-drop flag; a redirect wins over issue
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_r       <= RESET_PC;
      req_addr_r <= '0;
      drop_r     <= 1'b0;
    end else begin
      if (i_redirect_valid) begin
        pc_r <= i_redirect_pc & {{(XLEN-2){1'b1}}, 2'b00};
      end else if (issue_s) begin
        pc_r <= pc_r + XLEN'(3'd4);
      end
      if (issue_s) begin
        req_addr_r <= pc_r;
      end
      // Only one response is ever outstanding, so the flag is a single bit.
      if ((state_r == FS_WAIT) && i_mem_rsp_valid) begin
        drop_r <= 1'b0;
      end else if (i_redirect_valid && ((state_r == FS_REQ) || (state_r == FS_WAIT))) begin
        drop_r <= 1'b1;
      end
    end
  end

  ysyx_23060191_ifu_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .flush      (i_redirect_valid),
    .push       (push_s),
    .push_data  ({i_mem_rsp_err, req_addr_r, i_mem_rsp_data}),
    .pop        (pop_s),
    .head       (head_s),
    .head_valid (head_valid_s),
    .count      (fifo_count_s)
  );

  assign o_inst_valid = head_valid_s;
  assign o_inst_err   = head_s[EW-1];
  assign o_inst_pc    = head_s[2*XLEN-1:XLEN];
  assign o_inst       = head_s[XLEN-1:0];

  ysyx_23060191_ifu_prefetch_chk #(
    .DEPTH (DEPTH)
  ) u_chk (
    .clk       (clk),
    .rst       (rst),
    .state     (state_r),
    .rsp_valid (i_mem_rsp_valid),
    .push      (push_s),
    .count     (fifo_count_s)
  );

endmodule

// File: tb/tb_ysyx_23060191_ifu_prefetch.sv
// Directed bench for the fetch unit: a cycle table for the basic fetch path,
// then hand-written sequences for back-pressure, stalls and redirects.
module tb_ysyx_23060191_ifu_prefetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_redirect_valid;
  logic [31:0] i_redirect_pc;
  logic        o_mem_req_valid;
  logic [31:0] o_mem_req_addr;
  logic        i_mem_req_ready;
  logic        i_mem_rsp_valid;
  logic [31:0] i_mem_rsp_data;
  logic        i_mem_rsp_err;
  logic        o_inst_valid;
  logic [31:0] o_inst;
  logic [31:0] o_inst_pc;
  logic        o_inst_err;
  logic        i_inst_ready;

  always #5 clk = ~clk;

  ysyx_23060191_ifu_prefetch dut (
    .clk              (clk),
    .rst              (rst),
    .i_redirect_valid (i_redirect_valid),
    .i_redirect_pc    (i_redirect_pc),
    .o_mem_req_valid  (o_mem_req_valid),
    .o_mem_req_addr   (o_mem_req_addr),
    .i_mem_req_ready  (i_mem_req_ready),
    .i_mem_rsp_valid  (i_mem_rsp_valid),
    .i_mem_rsp_data   (i_mem_rsp_data),
    .i_mem_rsp_err    (i_mem_rsp_err),
    .o_inst_valid     (o_inst_valid),
    .o_inst           (o_inst),
    .o_inst_pc        (o_inst_pc),
    .o_inst_err       (o_inst_err),
    .i_inst_ready     (i_inst_ready)
  );

  typedef struct packed {
    logic        req_ready;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic        inst_ready;
    logic        exp_req_valid;
    logic [31:0] exp_req_addr;
    logic        exp_inst_valid;
    logic [31:0] exp_inst;
    logic [31:0] exp_pc;
    logic        exp_err;
  } vec_t;

  int          n_vec = 0;
  int          n_fail = 0;
  int          fire_cnt = 0;
  bit          auto_rsp = 1'b0;
  bit          fire_prev;
  logic [31:0] last_addr;
  vec_t        tbl [11];

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return a ^ 32'h8000_0013;
  endfunction

  function automatic vec_t mkv(input logic rr, input logic rv, input logic [31:0] rd,
                               input logic re, input logic ir, input logic eqv,
                               input logic [31:0] eqa, input logic eiv,
                               input logic [31:0] ei, input logic [31:0] ep, input logic ee);
    vec_t v;
    v.req_ready = rr; v.rsp_valid = rv; v.rsp_data = rd; v.rsp_err = re; v.inst_ready = ir;
    v.exp_req_valid = eqv; v.exp_req_addr = eqa; v.exp_inst_valid = eiv;
    v.exp_inst = ei; v.exp_pc = ep; v.exp_err = ee;
    return v;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance one clock; called and returns at a falling edge. The optional
  // memory model answers one cycle after each accepted request.
  task automatic tick();
    fire_prev = (rst === 1'b0) && (o_mem_req_valid === 1'b1) && (i_mem_req_ready === 1'b1);
    last_addr = o_mem_req_addr;
    if (fire_prev) fire_cnt++;
    @(posedge clk);
    @(negedge clk);
    if (auto_rsp) begin
      i_mem_rsp_valid = fire_prev;
      i_mem_rsp_data  = mem_data(last_addr);
      i_mem_rsp_err   = 1'b0;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    i_redirect_valid = 1'b0;
    i_redirect_pc    = 32'h0;
    i_mem_req_ready  = 1'b0;
    i_mem_rsp_valid  = 1'b0;
    i_mem_rsp_data   = 32'h0;
    i_mem_rsp_err    = 1'b0;
    i_inst_ready     = 1'b0;
    auto_rsp         = 1'b0;
    tick();
    chk("reset_outputs", {o_mem_req_valid, o_inst_valid, o_inst, o_inst_pc, o_inst_err}, 128'h0);
    tick();
    rst = 1'b0;
    fire_cnt = 0;
  endtask

  logic [63:0] popped [$];
  logic [63:0] pv;
  logic [31:0] first_req;
  bit          seen_req;

  initial begin
    // rr rv data err ir | req_v req_addr inst_v inst pc err
    tbl[0]  = mkv(1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 32'h0,        32'h0,         1'b0);
    tbl[1]  = mkv(1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 32'h8000_0000, 1'b0, 32'h0,        32'h0,         1'b0);
    tbl[2]  = mkv(1'b1, 1'b1, 32'h0000_0013, 1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        32'h0,         1'b0);
    tbl[3]  = mkv(1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 32'h0000_0013, 32'h8000_0000, 1'b0);
    tbl[4]  = mkv(1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 32'h8000_0004, 1'b0, 32'h0,        32'h0,         1'b0);
    tbl[5]  = mkv(1'b1, 1'b1, 32'h0000_0017, 1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        32'h0,         1'b0);
    tbl[6]  = mkv(1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 32'h0000_0017, 32'h8000_0004, 1'b1);
    tbl[7]  = mkv(1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 32'h8000_0008, 1'b0, 32'h0,        32'h0,         1'b0);
    tbl[8]  = mkv(1'b1, 1'b1, 32'h0000_001b, 1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        32'h0,         1'b0);
    tbl[9]  = mkv(1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 32'h0000_001b, 32'h8000_0008, 1'b0);
    tbl[10] = mkv(1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 32'h8000_000c, 1'b0, 32'h0,        32'h0,         1'b0);

    // Basic zero-wait fetch, including an access fault at 0x80000004
    @(negedge clk);
    do_reset();
    for (int k = 0; k < 11; k++) begin
      i_mem_req_ready = tbl[k].req_ready;
      i_mem_rsp_valid = tbl[k].rsp_valid;
      i_mem_rsp_data  = tbl[k].rsp_data;
      i_mem_rsp_err   = tbl[k].rsp_err;
      i_inst_ready    = tbl[k].inst_ready;
      chk($sformatf("vec%0d", k),
          {o_mem_req_valid, (o_mem_req_valid ? o_mem_req_addr : 32'h0),
           o_inst_valid, (o_inst_valid ? o_inst : 32'h0),
           (o_inst_valid ? o_inst_pc : 32'h0), (o_inst_valid ? o_inst_err : 1'b0)},
          {tbl[k].exp_req_valid, tbl[k].exp_req_addr, tbl[k].exp_inst_valid,
           tbl[k].exp_inst, tbl[k].exp_pc, tbl[k].exp_err});
      tick();
    end
    i_mem_rsp_valid = 1'b0;
    i_mem_rsp_err   = 1'b0;

    // Decoder stalled: exactly DEPTH requests, then drain in order and resume
    do_reset();
    auto_rsp = 1'b1;
    i_mem_req_ready = 1'b1;
    for (int i = 0; i < 30; i++) tick();
    chk("stall_req_count", 128'(fire_cnt), 128'd4);
    chk("stall_req_idle", {o_mem_req_valid, o_inst_valid}, {1'b0, 1'b1});
    i_inst_ready = 1'b1;
    seen_req = 1'b0;
    first_req = 32'h0;
    for (int i = 0; i < 30; i++) begin
      if (o_inst_valid) popped.push_back({o_inst_pc, o_inst});
      if (o_mem_req_valid && !seen_req) begin
        seen_req  = 1'b1;
        first_req = o_mem_req_addr;
      end
      tick();
    end
    chk("resume_addr", {seen_req, first_req}, {1'b1, 32'h8000_0010});
    for (int k = 0; k < 5; k++) begin
      pv = (k < popped.size()) ? popped[k] : 64'hx;
      chk($sformatf("drain%0d", k), pv,
          {32'h8000_0000 + 32'(4 * k), mem_data(32'h8000_0000 + 32'(4 * k))});
    end

    // Memory not ready for 5 cycles: request held stable, accepted once
    do_reset();
    auto_rsp = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("hold%0d", i), {o_mem_req_valid, o_mem_req_addr}, {1'b1, 32'h8000_0000});
      tick();
    end
    i_mem_req_ready = 1'b1;
    tick();
    i_mem_req_ready = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk("hold_accepts", 128'(fire_cnt), 128'd1);
    chk("hold_entry", {o_inst_valid, o_inst_pc}, {1'b1, 32'h8000_0000});
    i_inst_ready = 1'b1;
    tick();
    i_inst_ready = 1'b0;
    chk("hold_one_entry", o_inst_valid, 1'b0);

    // Redirect while waiting for a response: queue flushed, response dropped
    do_reset();
    i_mem_req_ready = 1'b1;
    tick();
    tick();
    i_mem_rsp_valid = 1'b1; i_mem_rsp_data = mem_data(32'h8000_0000);
    tick();
    i_mem_rsp_valid = 1'b0;
    chk("t4_queued", o_inst_valid, 1'b1);
    tick();
    tick();
    tick();
    i_redirect_valid = 1'b1; i_redirect_pc = 32'h8000_1002;
    tick();
    i_redirect_valid = 1'b0;
    chk("t4_flushed", o_inst_valid, 1'b0);
    i_mem_rsp_valid = 1'b1; i_mem_rsp_data = 32'hdead_beef;
    tick();
    i_mem_rsp_valid = 1'b0;
    chk("t4_dropped", o_inst_valid, 1'b0);
    tick();
    chk("t4_req", {o_mem_req_valid, o_mem_req_addr}, {1'b1, 32'h8000_1000});
    tick();
    i_mem_rsp_valid = 1'b1; i_mem_rsp_data = mem_data(32'h8000_1000);
    tick();
    i_mem_rsp_valid = 1'b0;
    chk("t4_head", {o_inst_valid, o_inst_pc, o_inst},
        {1'b1, 32'h8000_1000, mem_data(32'h8000_1000)});

    // Redirect coinciding with a response and a pop
    do_reset();
    i_mem_req_ready = 1'b1;
    tick();
    tick();
    i_mem_rsp_valid = 1'b1; i_mem_rsp_data = mem_data(32'h8000_0000);
    tick();
    i_mem_rsp_valid = 1'b0;
    tick();
    tick();
    chk("t5_head_before", o_inst_valid, 1'b1);
    i_mem_rsp_valid  = 1'b1; i_mem_rsp_data = mem_data(32'h8000_0004);
    i_redirect_valid = 1'b1; i_redirect_pc = 32'h8000_2000;
    i_inst_ready     = 1'b1;
    tick();
    i_mem_rsp_valid = 1'b0; i_redirect_valid = 1'b0; i_inst_ready = 1'b0;
    chk("t5_empty", o_inst_valid, 1'b0);
    tick();
    chk("t5_req", {o_mem_req_valid, o_mem_req_addr}, {1'b1, 32'h8000_2000});
    tick();
    i_mem_rsp_valid = 1'b1; i_mem_rsp_data = mem_data(32'h8000_2000);
    tick();
    i_mem_rsp_valid = 1'b0;
    chk("t5_head", {o_inst_valid, o_inst_pc}, {1'b1, 32'h8000_2000});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
